matrix_tile_regfile: RTL and testbench
======================================

MATRIX_TILE_REGFILE -- requirements
Module: matrix_tile_regfile

Interface
REQ-001 Parameter READ_PORTS, default 3: number of random-access row read ports.
REQ-002 Parameter WRITE_PORTS, default 2: number of row write ports.
REQ-003 Parameter STREAM_PORTS, default 2: number of whole-register streaming read channels.
REQ-004 Parameter N_REGS, default 8: number of matrix registers, power of two, at least 2.
REQ-005 Parameter RLEN, default 128: row width in bits, power of two, below 2^16.
REQ-006 Parameter N_ROWS, default RLEN/32: rows per register, power of two, at least 2.
REQ-007 Ports, clock and reset first. One clock; reset is asynchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- raddr_i  in  READ_PORTS x clog2(N_REGS)  read register address.
- rrowaddr_i  in  READ_PORTS x clog2(N_ROWS)  read row address.
- rdata_o  out  READ_PORTS x RLEN  read row data.
- waddr_i  in  WRITE_PORTS x clog2(N_REGS)  write register address.
- wrowaddr_i  in  WRITE_PORTS x clog2(N_ROWS)  write row address.
- wdata_i  in  WRITE_PORTS x RLEN  write row data.
- we_i  in  WRITE_PORTS  write enable.
- wconflict_o  out  1  two or more enabled writes target the same row this cycle.
- zero_valid_i  in  1  clear a whole register.
- zero_addr_i  in  clog2(N_REGS)  register to clear.
- sreq_valid_i  in  STREAM_PORTS  stream request valid.
- sreq_ready_o  out  STREAM_PORTS  stream request accepted.
- sreq_addr_i  in  STREAM_PORTS x clog2(N_REGS)  register to stream.
- s_valid_o  out  STREAM_PORTS  stream row valid.
- s_ready_i  in  STREAM_PORTS  stream row consumed.
- s_data_o  out  STREAM_PORTS x RLEN  stream row data.
- s_row_o  out  STREAM_PORTS x clog2(N_ROWS)  index of the current row.
- s_last_o  out  STREAM_PORTS  current row is row N_ROWS-1.

Function
REQ-008 rdata_o[j] SHALL be a combinational read of the registered state, mem_q[raddr_i[j]][rrowaddr_i[j]]; there is no write-to-read bypass.
REQ-009 An enabled write SHALL update its row at the next clk_i edge; if several enabled writes target the same register and row, the highest-indexed port SHALL win.
REQ-010 wconflict_o SHALL be combinational and high exactly when REQ-009 arbitration selects a winner among two or more writes.
REQ-011 zero_valid_i SHALL clear every row of zero_addr_i at the next edge; any port write to that register in the same cycle SHALL override the clear for its own row.
REQ-012 Each stream channel SHALL run an FSM with states IDLE and STREAM.
- In IDLE: sreq_ready_o=1 and s_valid_o=0.
- In STREAM: sreq_ready_o=0 and s_valid_o=1.
REQ-013 IDLE with sreq_valid_i=1 SHALL latch sreq_addr_i, set the row counter to 0, and enter STREAM; the first row is valid one cycle after acceptance.
REQ-014 In STREAM, s_data_o SHALL be mem_q[latched reg][row counter], read live, so a row written before it is consumed shows the new data.
REQ-015 The row counter SHALL advance only on s_valid_o and s_ready_i both high; it SHALL hold while s_ready_i=0, and s_data_o SHALL follow live memory while stalled.
REQ-016 A handshake with s_last_o=1 SHALL return the channel to IDLE; a request is accepted no earlier than the following cycle, so there are no back-to-back streams.
REQ-017 Channels SHALL be independent; several channels may stream the same register at once.

Reset
REQ-018 On rst_i asserted, SHALL clear all register rows to 0 and force all channels to IDLE with counters at 0, asynchronously and regardless of clk_i.
REQ-019 During reset: s_valid_o=0, sreq_ready_o=1, s_row_o=0, s_last_o=0. rdata_o and s_data_o read 0. wconflict_o is combinational per REQ-010. A stream interrupted by reset SHALL be abandoned and not resumed.

Structure
REQ-020 The shared package matrix_rf_pkg SHALL hold the stream FSM enum (STREAM_IDLE, STREAM_ACTIVE) and the row/address width helper functions.
REQ-021 The per-channel FSM SHALL be the sub-module matrix_rf_stream_reader, instantiated STREAM_PORTS times; storage and write arbitration stay in the top module.

Verification
REQ-022 Write reg 3 row 1 with 0xA5A5 on port 0; next cycle set raddr=3, rrowaddr=1 -> rdata_o=0xA5A5; in the write cycle itself the read returns the old value 0.
REQ-023 Ports 0 and 1 write reg 2 row 0 with 0x11 and 0x22 in the same cycle -> wconflict_o=1 that cycle, and the row reads 0x22 afterwards.
REQ-024 Clear reg 5 (rows preloaded 1..4) while port 0 writes 0x77 to reg 5 row 2 -> rows read 0, 0, 0x77, 0.
REQ-025 Stream reg 4 on channel 0 with s_ready_i toggling 1,0,1,1,1 -> rows 0..3 delivered in order, s_row_o holds during the stall, s_last_o=1 only with row 3, then sreq_ready_o=1.
REQ-026 Assert rst_i in the middle of a stream at row 2 -> s_valid_o=0 at once, all rows read 0, and a new request is accepted after rst_i is released.

Source files
------------

// File: rtl/matrix_rf_pkg.sv
// Shared types and width helpers for the matrix tile register file.
// Holds the per-channel stream FSM encoding and the address width helpers.
package matrix_rf_pkg;

   typedef enum logic {
      STREAM_IDLE   = 1'b0,
      STREAM_ACTIVE = 1'b1
   } stream_state_e;

   // A single-entry space still needs a one-bit address.
   function automatic int unsigned reg_addr_w(input int unsigned n_regs);
      return (n_regs > 1) ? $clog2(n_regs) : 1;
   endfunction

   function automatic int unsigned row_addr_w(input int unsigned n_rows);
      return (n_rows > 1) ? $clog2(n_rows) : 1;
   endfunction

endpackage

// File: rtl/matrix_rf_stream_reader.sv
// One streaming channel: accepts a register index, then walks its rows 0..N_ROWS-1.
// First row is valid the cycle after acceptance; the row counter holds while s_ready_i is low.
module matrix_rf_stream_reader
   import matrix_rf_pkg::*;
#(
   parameter int unsigned N_REGS = 8,
   parameter int unsigned N_ROWS = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      sreq_valid_i,
   output logic                      sreq_ready_o,
   input  logic [$clog2(N_REGS)-1:0] sreq_addr_i,
   output logic                      s_valid_o,
   input  logic                      s_ready_i,
   output logic [$clog2(N_ROWS)-1:0] s_row_o,
   output logic                      s_last_o,
   output logic [$clog2(N_REGS)-1:0] s_reg_o
);

   localparam int unsigned AW = reg_addr_w(N_REGS);
   localparam int unsigned RW = row_addr_w(N_ROWS);
   localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);

   stream_state_e state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW-1:0] reg_q, reg_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= STREAM_IDLE;
         row_q   <= '0;
         reg_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         reg_q   <= reg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      reg_d   = reg_q;
      case (state_q)
         STREAM_IDLE: begin
            if (sreq_valid_i) begin
               state_d = STREAM_ACTIVE;
               row_d   = '0;
               reg_d   = sreq_addr_i;
            end
         end
         STREAM_ACTIVE: begin
            if (s_ready_i) begin
               // The last handshake drops back to idle; a new request waits one cycle.
               if (row_q == LAST_ROW) begin
                  state_d = STREAM_IDLE;
                  row_d   = '0;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         default: state_d = STREAM_IDLE;
      endcase
   end

   always_comb begin
      sreq_ready_o = (state_q == STREAM_IDLE);
      s_valid_o    = (state_q == STREAM_ACTIVE);
      s_last_o     = (state_q == STREAM_ACTIVE) && (row_q == LAST_ROW);
      s_row_o      = row_q;
      s_reg_o      = reg_q;
   end

   a_valid_ready_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
      s_valid_o != sreq_ready_o);

   a_row_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
      row_q <= LAST_ROW);

endmodule

// File: rtl/matrix_tile_regfile.sv
// Matrix tile register file: row-granular read/write ports, whole-register clear, streaming readers.
// Reads are combinational from registered state; writes land on the next edge; streams stall on s_ready_i.
module matrix_tile_regfile
   import matrix_rf_pkg::*;
#(
   parameter int unsigned READ_PORTS   = 3,
   parameter int unsigned WRITE_PORTS  = 2,
   parameter int unsigned STREAM_PORTS = 2,
   parameter int unsigned N_REGS       = 8,
   parameter int unsigned RLEN         = 128,
   parameter int unsigned N_ROWS       = RLEN / 32
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic [READ_PORTS-1:0][$clog2(N_REGS)-1:0]   raddr_i,
   input  logic [READ_PORTS-1:0][$clog2(N_ROWS)-1:0]   rrowaddr_i,
   output logic [READ_PORTS-1:0][RLEN-1:0]             rdata_o,
   input  logic [WRITE_PORTS-1:0][$clog2(N_REGS)-1:0]  waddr_i,
   input  logic [WRITE_PORTS-1:0][$clog2(N_ROWS)-1:0]  wrowaddr_i,
   input  logic [WRITE_PORTS-1:0][RLEN-1:0]            wdata_i,
   input  logic [WRITE_PORTS-1:0]                      we_i,
   output logic                                        wconflict_o,
   input  logic                                        zero_valid_i,
   input  logic [$clog2(N_REGS)-1:0]                   zero_addr_i,
   input  logic [STREAM_PORTS-1:0]                     sreq_valid_i,
   output logic [STREAM_PORTS-1:0]                     sreq_ready_o,
   input  logic [STREAM_PORTS-1:0][$clog2(N_REGS)-1:0] sreq_addr_i,
   output logic [STREAM_PORTS-1:0]                     s_valid_o,
   input  logic [STREAM_PORTS-1:0]                     s_ready_i,
   output logic [STREAM_PORTS-1:0][RLEN-1:0]           s_data_o,
   output logic [STREAM_PORTS-1:0][$clog2(N_ROWS)-1:0] s_row_o,
   output logic [STREAM_PORTS-1:0]                     s_last_o
);

   localparam int unsigned AW = reg_addr_w(N_REGS);
   localparam int unsigned RW = row_addr_w(N_ROWS);

   if (N_REGS < 2 || (N_REGS & (N_REGS - 1)) != 0) begin : g_bad_n_regs
      $error("N_REGS must be a power of two and at least 2");
   end
   if (N_ROWS < 2 || (N_ROWS & (N_ROWS - 1)) != 0) begin : g_bad_n_rows
      $error("N_ROWS must be a power of two and at least 2");
   end
   if (RLEN >= 65536 || (RLEN & (RLEN - 1)) != 0) begin : g_bad_rlen
      $error("RLEN must be a power of two below 65536");
   end

   logic [RLEN-1:0] mem_q [N_REGS][N_ROWS];

   // Later statements win: ports override the clear, and higher ports override lower ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < N_REGS; r++) begin
            for (int w = 0; w < N_ROWS; w++) begin
               mem_q[r][w] <= '0;
            end
         end
      end else begin
         if (zero_valid_i) begin
            for (int w = 0; w < N_ROWS; w++) begin
               mem_q[zero_addr_i][w] <= '0;
            end
         end
         for (int p = 0; p < WRITE_PORTS; p++) begin
            if (we_i[p]) begin
               mem_q[waddr_i[p]][wrowaddr_i[p]] <= wdata_i[p];
            end
         end
      end
   end

   always_comb begin
      wconflict_o = 1'b0;
      for (int i = 0; i < WRITE_PORTS; i++) begin
         for (int j = i + 1; j < WRITE_PORTS; j++) begin
            if (we_i[i] && we_i[j] &&
                waddr_i[i] == waddr_i[j] && wrowaddr_i[i] == wrowaddr_i[j]) begin
               wconflict_o = 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int j = 0; j < READ_PORTS; j++) begin
         rdata_o[j] = mem_q[raddr_i[j]][rrowaddr_i[j]];
      end
   end

   logic [STREAM_PORTS-1:0][AW-1:0] s_reg;

   for (genvar c = 0; c < STREAM_PORTS; c++) begin : g_stream
      matrix_rf_stream_reader #(
         .N_REGS (N_REGS),
         .N_ROWS (N_ROWS)
      ) u_reader (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .sreq_valid_i (sreq_valid_i[c]),
         .sreq_ready_o (sreq_ready_o[c]),
         .sreq_addr_i  (sreq_addr_i[c]),
         .s_valid_o    (s_valid_o[c]),
         .s_ready_i    (s_ready_i[c]),
         .s_row_o      (s_row_o[c]),
         .s_last_o     (s_last_o[c]),
         .s_reg_o      (s_reg[c])
      );
   end

   // Stream data is a live read, so writes to a pending row show up before it is consumed.
   always_comb begin
      for (int c = 0; c < STREAM_PORTS; c++) begin
         s_data_o[c] = s_valid_o[c] ? mem_q[s_reg[c]][s_row_o[c]] : '0;
      end
   end

   logic [RW-1:0] unused_rw;
   assign unused_rw = '0;

endmodule

// File: tb/tb_matrix_tile_regfile.sv
// Randomized and directed bench for matrix_tile_regfile against a behavioural model.
module tb_matrix_tile_regfile;

   localparam int RP   = 3;
   localparam int WP   = 2;
   localparam int SP   = 2;
   localparam int NREG = 8;
   localparam int RLEN = 128;
   localparam int NROW = 4;
   localparam int AW   = 3;
   localparam int RW   = 2;

   logic clk_i = 1'b0;
   logic rst_i;
   logic [RP-1:0][AW-1:0]   raddr_i;
   logic [RP-1:0][RW-1:0]   rrowaddr_i;
   logic [RP-1:0][RLEN-1:0] rdata_o;
   logic [WP-1:0][AW-1:0]   waddr_i;
   logic [WP-1:0][RW-1:0]   wrowaddr_i;
   logic [WP-1:0][RLEN-1:0] wdata_i;
   logic [WP-1:0]           we_i;
   logic                    wconflict_o;
   logic                    zero_valid_i;
   logic [AW-1:0]           zero_addr_i;
   logic [SP-1:0]           sreq_valid_i;
   logic [SP-1:0]           sreq_ready_o;
   logic [SP-1:0][AW-1:0]   sreq_addr_i;
   logic [SP-1:0]           s_valid_o;
   logic [SP-1:0]           s_ready_i;
   logic [SP-1:0][RLEN-1:0] s_data_o;
   logic [SP-1:0][RW-1:0]   s_row_o;
   logic [SP-1:0]           s_last_o;

   matrix_tile_regfile #(
      .READ_PORTS   (RP),
      .WRITE_PORTS  (WP),
      .STREAM_PORTS (SP),
      .N_REGS       (NREG),
      .RLEN         (RLEN),
      .N_ROWS       (NROW)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .raddr_i      (raddr_i),
      .rrowaddr_i   (rrowaddr_i),
      .rdata_o      (rdata_o),
      .waddr_i      (waddr_i),
      .wrowaddr_i   (wrowaddr_i),
      .wdata_i      (wdata_i),
      .we_i         (we_i),
      .wconflict_o  (wconflict_o),
      .zero_valid_i (zero_valid_i),
      .zero_addr_i  (zero_addr_i),
      .sreq_valid_i (sreq_valid_i),
      .sreq_ready_o (sreq_ready_o),
      .sreq_addr_i  (sreq_addr_i),
      .s_valid_o    (s_valid_o),
      .s_ready_i    (s_ready_i),
      .s_data_o     (s_data_o),
      .s_row_o      (s_row_o),
      .s_last_o     (s_last_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural model: plain memory array plus "streaming reg R, at row K" per channel.
   logic [RLEN-1:0] m_mem [NREG][NROW];
   bit              m_act [SP];
   int              m_reg [SP];
   int              m_row [SP];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [RLEN-1:0] got, input logic [RLEN-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREG; r++)
         for (int w = 0; w < NROW; w++)
            m_mem[r][w] = '0;
      for (int c = 0; c < SP; c++) begin
         m_act[c] = 1'b0;
         m_reg[c] = 0;
         m_row[c] = 0;
      end
   endtask

   task automatic model_check();
      int hits [NREG*NROW];
      bit exp_conf;
      for (int j = 0; j < RP; j++)
         check($sformatf("rdata[%0d]", j), rdata_o[j], m_mem[raddr_i[j]][rrowaddr_i[j]]);
      for (int k = 0; k < NREG*NROW; k++) hits[k] = 0;
      for (int p = 0; p < WP; p++)
         if (we_i[p]) hits[int'(waddr_i[p])*NROW + int'(wrowaddr_i[p])]++;
      exp_conf = 1'b0;
      for (int k = 0; k < NREG*NROW; k++) if (hits[k] >= 2) exp_conf = 1'b1;
      check("wconflict", RLEN'(wconflict_o), RLEN'(exp_conf));
      for (int c = 0; c < SP; c++) begin
         check($sformatf("sreq_ready[%0d]", c), RLEN'(sreq_ready_o[c]), RLEN'(!m_act[c]));
         check($sformatf("s_valid[%0d]", c), RLEN'(s_valid_o[c]), RLEN'(m_act[c]));
         check($sformatf("s_row[%0d]", c), RLEN'(s_row_o[c]), RLEN'(m_act[c] ? m_row[c] : 0));
         check($sformatf("s_last[%0d]", c), RLEN'(s_last_o[c]),
               RLEN'(m_act[c] && m_row[c] == NROW-1));
         check($sformatf("s_data[%0d]", c), s_data_o[c],
               m_act[c] ? m_mem[m_reg[c]][m_row[c]] : '0);
      end
   endtask

   task automatic model_step();
      if (zero_valid_i)
         for (int w = 0; w < NROW; w++) m_mem[zero_addr_i][w] = '0;
      for (int p = 0; p < WP; p++)
         if (we_i[p]) m_mem[waddr_i[p]][wrowaddr_i[p]] = wdata_i[p];
      for (int c = 0; c < SP; c++) begin
         if (!m_act[c]) begin
            if (sreq_valid_i[c]) begin
               m_act[c] = 1'b1;
               m_reg[c] = int'(sreq_addr_i[c]);
               m_row[c] = 0;
            end
         end else if (s_ready_i[c]) begin
            if (m_row[c] == NROW-1) m_act[c] = 1'b0;
            else m_row[c] = m_row[c] + 1;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_check();
   endtask

   task automatic advance();
      model_step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle_inputs();
      raddr_i      = '0;
      rrowaddr_i   = '0;
      waddr_i      = '0;
      wrowaddr_i   = '0;
      wdata_i      = '0;
      we_i         = '0;
      zero_valid_i = 1'b0;
      zero_addr_i  = '0;
      sreq_valid_i = '0;
      sreq_addr_i  = '0;
      s_ready_i    = '0;
   endtask

   task automatic write1(input int port, input int r, input int w, input logic [RLEN-1:0] d);
      we_i[port]       = 1'b1;
      waddr_i[port]    = AW'(r);
      wrowaddr_i[port] = RW'(w);
      wdata_i[port]    = d;
   endtask

   int rdy_seq [5] = '{1, 0, 1, 1, 1};
   int row_seq [5] = '{0, 1, 1, 2, 3};

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      model_reset();
      @(negedge clk_i);
      settle();
      check("rst sreq_ready", RLEN'(sreq_ready_o), RLEN'(2'b11));
      check("rst s_valid", RLEN'(s_valid_o), '0);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Write then read back; the write cycle itself still reads the old value.
      write1(0, 3, 1, 128'hA5A5);
      raddr_i[0] = 3'd3; rrowaddr_i[0] = 2'd1;
      settle();
      check("wr cycle old", rdata_o[0], '0);
      advance();
      we_i = '0;
      settle();
      check("wr readback", rdata_o[0], 128'hA5A5);
      advance();

      // Same-row collision: port 1 wins.
      write1(0, 2, 0, 128'h11);
      write1(1, 2, 0, 128'h22);
      settle();
      check("conflict flag", RLEN'(wconflict_o), RLEN'(1));
      advance();
      we_i = '0;
      raddr_i[1] = 3'd2; rrowaddr_i[1] = 2'd0;
      settle();
      check("conflict winner", rdata_o[1], 128'h22);
      advance();

      // Clear with a same-cycle row write overriding it.
      write1(0, 5, 0, 128'd1); write1(1, 5, 1, 128'd2);
      settle(); advance();
      write1(0, 5, 2, 128'd3); write1(1, 5, 3, 128'd4);
      settle(); advance();
      we_i = '0;
      zero_valid_i = 1'b1; zero_addr_i = 3'd5;
      write1(0, 5, 2, 128'h77);
      settle(); advance();
      idle_inputs();
      for (int j = 0; j < RP; j++) begin
         raddr_i[j] = 3'd5; rrowaddr_i[j] = RW'(j);
      end
      settle();
      check("clr row0", rdata_o[0], '0);
      check("clr row1", rdata_o[1], '0);
      check("clr row2", rdata_o[2], 128'h77);
      advance();
      rrowaddr_i[0] = 2'd3;
      settle();
      check("clr row3", rdata_o[0], '0);
      advance();

      // Stream reg 4 with a one-cycle stall.
      idle_inputs();
      write1(0, 4, 0, 128'h400); write1(1, 4, 1, 128'h401);
      settle(); advance();
      write1(0, 4, 2, 128'h402); write1(1, 4, 3, 128'h403);
      settle(); advance();
      idle_inputs();
      sreq_valid_i[0] = 1'b1; sreq_addr_i[0] = 3'd4;
      settle();
      check("strm accept rdy", RLEN'(sreq_ready_o[0]), RLEN'(1));
      advance();
      sreq_valid_i[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_ready_i[0] = rdy_seq[i][0];
         settle();
         check("strm valid", RLEN'(s_valid_o[0]), RLEN'(1));
         check("strm row", RLEN'(s_row_o[0]), RLEN'(row_seq[i]));
         check("strm last", RLEN'(s_last_o[0]), RLEN'(i == 4));
         check("strm data", s_data_o[0], RLEN'(32'h400 + row_seq[i]));
         advance();
      end
      s_ready_i[0] = 1'b0;
      settle();
      check("strm done rdy", RLEN'(sreq_ready_o[0]), RLEN'(1));
      check("strm done vld", RLEN'(s_valid_o[0]), '0);
      advance();

      // Reset in the middle of a stream at row 2.
      sreq_valid_i[0] = 1'b1; sreq_addr_i[0] = 3'd3;
      raddr_i[0] = 3'd3; rrowaddr_i[0] = 2'd1;
      settle(); advance();
      sreq_valid_i[0] = 1'b0;
      s_ready_i[0] = 1'b1;
      settle(); advance();
      settle(); advance();
      s_ready_i[0] = 1'b0;
      settle();
      check("pre-rst row", RLEN'(s_row_o[0]), RLEN'(2));
      check("pre-rst data", rdata_o[0], 128'hA5A5);
      rst_i = 1'b1;
      #1;
      model_reset();
      model_check();
      check("rst s_valid", RLEN'(s_valid_o[0]), '0);
      check("rst rdata", rdata_o[0], '0);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      sreq_valid_i[0] = 1'b1; sreq_addr_i[0] = 3'd4;
      settle();
      check("post-rst rdy", RLEN'(sreq_ready_o[0]), RLEN'(1));
      advance();
      sreq_valid_i[0] = 1'b0;
      settle();
      check("post-rst vld", RLEN'(s_valid_o[0]), RLEN'(1));
      check("post-rst row", RLEN'(s_row_o[0]), '0);
      advance();

      // Random traffic, narrow write addresses to provoke collisions and shared streams.
      for (int n = 0; n < 600; n++) begin
         for (int j = 0; j < RP; j++) begin
            raddr_i[j]    = AW'($urandom_range(0, NREG-1));
            rrowaddr_i[j] = RW'($urandom_range(0, NROW-1));
         end
         for (int p = 0; p < WP; p++) begin
            we_i[p]       = ($urandom_range(0, 2) != 0);
            waddr_i[p]    = AW'($urandom_range(0, 3));
            wrowaddr_i[p] = RW'($urandom_range(0, NROW-1));
            wdata_i[p]    = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         zero_valid_i = ($urandom_range(0, 7) == 0);
         zero_addr_i  = AW'($urandom_range(0, 3));
         for (int c = 0; c < SP; c++) begin
            sreq_valid_i[c] = ($urandom_range(0, 2) == 0);
            sreq_addr_i[c]  = AW'($urandom_range(0, 3));
            s_ready_i[c]    = ($urandom_range(0, 3) != 0);
         end
         settle();
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
